// File: rtl/led_matrix_pwm_driver_pkg.sv
// led_pkg
// Shared definitions for the bicolour LED matrix PWM driver.
//   row_width()  : width of a row index for a given row count
//   pixel_t      : one colour intensity of one pixel (default geometry)
//   frame_t      : one full colour plane (default geometry)
//   scan_state_t : scan controller states
// No ports.
package led_pkg;

    localparam int DEFAULT_ROWS     = 16;
    localparam int DEFAULT_COLS     = 16;
    localparam int DEFAULT_PWM_BITS = 2;

    // A single-row matrix still needs a one-bit row select.
    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Default-geometry types; parameterised modules build their own
    // equivalents from their parameters.
    typedef logic [DEFAULT_PWM_BITS-1:0] pixel_t;
    typedef pixel_t [DEFAULT_ROWS-1:0][DEFAULT_COLS-1:0] frame_t;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        SCAN  = 2'd1,
        SWAP  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/led_matrix_pwm_driver_scan_timer.sv
// led_scan_timer
// Prescaler, PWM phase counter and row counter for the matrix scan.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   EnableCount  : counters advance only while high
//   tick         : one scan step happens at the end of this cycle
//   phase        : current PWM phase within the row
//   row          : current row
//   boundary     : counters sit on the last row and last phase
module led_scan_timer import led_pkg::*; #(
    parameter int ROWS     = 16,
    parameter int PWM_BITS = 2,
    parameter int FREQDIV  = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       EnableCount,
    output logic                       tick,
    output logic [PWM_BITS-1:0]        phase,
    output logic [row_width(ROWS)-1:0] row,
    output logic                       boundary
);

    localparam int ROW_W = row_width(ROWS);

    logic presc_wrap;
    logic last_phase;
    logic last_row;

    // The prescaler only exists when a divide is requested; with no divide
    // every enabled clock is a scan tick.
    generate
        if (FREQDIV == 0) begin : g_no_prescale
            assign presc_wrap = 1'b1;
        end else begin : g_prescale
            logic [FREQDIV-1:0] prescaler;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    prescaler <= '0;
                end else if (EnableCount) begin
                    prescaler <= prescaler + FREQDIV'(1);
                end
            end

            assign presc_wrap = &prescaler;
        end
    endgenerate

    assign tick       = EnableCount & presc_wrap;
    assign last_phase = &phase;
    // Compared against ROWS-1 so a row count below the counter range wraps early.
    assign last_row   = (row == ROW_W'(ROWS - 1));
    assign boundary   = last_row & last_phase;

    // Phase runs every tick; row advances when the phase wraps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase <= '0;
            row   <= '0;
        end else if (tick) begin
            phase <= phase + PWM_BITS'(1);
            if (last_phase) begin
                row <= last_row ? '0 : row + ROW_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_matrix_pwm_driver.sv
// led_matrix_pwm_driver
// Bicolour ROWS x COLS LED matrix scanner with per-pixel PWM and a
// tear-free double buffer.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   EnableCount           : run/freeze the scan
//   RedPixels, GrnPixels  : frame data, sampled when FrameValid && FrameReady
//   FrameValid/FrameReady : frame handshake into the shadow buffer
//   FrameStart            : pulse aligned with the first row-0 output of a frame
//   RowSel                : row being driven
//   RedCols, GrnCols      : column drive; bit COLS-1-c shows pixel column c
module led_matrix_pwm_driver import led_pkg::*; #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int PWM_BITS = 2,
    parameter int FREQDIV  = 0
) (
    input  logic                                    CLK,
    input  logic                                    RST_N,
    input  logic                                    EnableCount,
    input  logic [ROWS-1:0][COLS-1:0][PWM_BITS-1:0] RedPixels,
    input  logic [ROWS-1:0][COLS-1:0][PWM_BITS-1:0] GrnPixels,
    input  logic                                    FrameValid,
    output logic                                    FrameReady,
    output logic                                    FrameStart,
    output logic [row_width(ROWS)-1:0]              RowSel,
    output logic [COLS-1:0]                         RedCols,
    output logic [COLS-1:0]                         GrnCols
);

    localparam int ROW_W = row_width(ROWS);

    typedef logic [ROWS-1:0][COLS-1:0][PWM_BITS-1:0] plane_t;

    plane_t              shadow_red;
    plane_t              shadow_grn;
    plane_t              active_red;
    plane_t              active_grn;
    logic                pending;
    logic                capture;
    logic                swap_en;
    logic                tick;
    logic                boundary;
    logic                boundary_q;
    logic [PWM_BITS-1:0] phase;
    logic [ROW_W-1:0]    row;
    logic [COLS-1:0]     red_next;
    logic [COLS-1:0]     grn_next;
    scan_state_t         state;
    scan_state_t         state_next;

    led_scan_timer #(
        .ROWS     (ROWS),
        .PWM_BITS (PWM_BITS),
        .FREQDIV  (FREQDIV)
    ) u_timer (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EnableCount (EnableCount),
        .tick        (tick),
        .phase       (phase),
        .row         (row),
        .boundary    (boundary)
    );

    assign FrameReady = ~pending;
    assign capture    = FrameValid & ~pending;

    // Scan controller state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RESET;
        end else begin
            state <= state_next;
        end
    end

    // SWAP marks the single cycle after a frame boundary that promoted the shadow.
    always_comb begin
        state_next = state;
        case (state)
            RESET:   state_next = SCAN;
            SCAN:    if (tick && boundary && pending) state_next = SWAP;
            SWAP:    state_next = SCAN;
            default: state_next = RESET;
        endcase
    end

    // The copy happens on the boundary tick itself so row 0 of the new frame
    // is already computed from the new buffer.
    always_comb begin
        swap_en = 1'b0;
        if (state == SCAN) begin
            swap_en = tick & boundary & pending;
        end
    end

    // Shadow capture, shadow-to-active promotion and the pending flag.
    // Capture and swap are mutually exclusive because capture needs !pending.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_red <= '0;
            shadow_grn <= '0;
            active_red <= '0;
            active_grn <= '0;
            pending    <= 1'b0;
        end else begin
            if (capture) begin
                shadow_red <= RedPixels;
                shadow_grn <= GrnPixels;
            end
            if (swap_en) begin
                active_red <= shadow_red;
                active_grn <= shadow_grn;
            end
            if (swap_en) begin
                pending <= 1'b0;
            end else if (capture) begin
                pending <= 1'b1;
            end
        end
    end

    // PWM compare: intensity 0 never lights, full scale misses only the top phase.
    always_comb begin
        red_next = '0;
        grn_next = '0;
        for (int c = 0; c < COLS; c++) begin
            red_next[COLS-1-c] = active_red[row][c] > phase;
            grn_next[COLS-1-c] = active_grn[row][c] > phase;
        end
    end

    // Output registers trail the counters by one cycle; FrameStart is delayed
    // twice so it lines up with the first registered row-0 output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RowSel     <= '0;
            RedCols    <= '0;
            GrnCols    <= '0;
            boundary_q <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            RowSel     <= row;
            RedCols    <= red_next;
            GrnCols    <= grn_next;
            boundary_q <= tick & boundary;
            FrameStart <= boundary_q;
        end
    end

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// tb_led_matrix_pwm_driver
// Directed bench for led_matrix_pwm_driver (16x16, 2-bit PWM, FREQDIV=2).
// A small frame-level model tracks scan position and which frame is shown;
// every cycle is compared, plus hand-computed spot checks at key moments.
module tb_led_matrix_pwm_driver;

    logic                    CLK = 1'b0;
    logic                    RST_N = 1'b0;
    logic                    EnableCount = 1'b0;
    logic                    FrameValid = 1'b0;
    logic [15:0][15:0][1:0]  RedPixels = '0;
    logic [15:0][15:0][1:0]  GrnPixels = '0;
    logic                    FrameReady;
    logic                    FrameStart;
    logic [3:0]              RowSel;
    logic [15:0]             RedCols;
    logic [15:0]             GrnCols;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: pos counts enabled edges since reset release.
    int pos      = 0;
    int mActive  = 0;
    int mShadow  = 0;
    int curId    = 0;
    bit mPending = 1'b0;
    bit bndQ     = 1'b0;

    led_matrix_pwm_driver #(
        .ROWS     (16),
        .COLS     (16),
        .PWM_BITS (2),
        .FREQDIV  (2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EnableCount (EnableCount),
        .RedPixels   (RedPixels),
        .GrnPixels   (GrnPixels),
        .FrameValid  (FrameValid),
        .FrameReady  (FrameReady),
        .FrameStart  (FrameStart),
        .RowSel      (RowSel),
        .RedCols     (RedCols),
        .GrnCols     (GrnCols)
    );

    always #5 CLK = ~CLK;

    // Hand-derived column images of each test frame for a given row/phase.
    function automatic logic [15:0] expRed(input int id, input int r, input int ph);
        case (id)
            1: return (r == 3 && ph < 3) ? 16'h8000 : 16'h0000;
            2: return (r == 5 && ph < 2) ? 16'h0100 : 16'h0000;
            3: return (r == 0 && ph < 1) ? 16'h0001 : 16'h0000;
            4: begin
                if (r == 1 && ph < 3) return 16'h4000;
                if (r == 7 && ph < 3) return 16'h2000;
                return 16'h0000;
            end
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] expGrn(input int id, input int r, input int ph);
        case (id)
            1: return (r == 3 && ph < 1) ? 16'h0001 : 16'h0000;
            2: return (r == 0 && ph < 3) ? 16'h8000 : 16'h0000;
            3: return (r == 15 && ph < 2) ? 16'h0080 : 16'h0000;
            5: return (r == 7 && ph < 3) ? 16'h1000 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame 9 is an all-on pattern used as "garbage" after a capture.
    task automatic applyStimulus(input int id, input bit valid);
        RedPixels = '0;
        GrnPixels = '0;
        case (id)
            1: begin RedPixels[3][0] = 2'd3; GrnPixels[3][15] = 2'd1; end
            2: begin RedPixels[5][7] = 2'd2; GrnPixels[0][0] = 2'd3; end
            3: begin RedPixels[0][15] = 2'd1; GrnPixels[15][8] = 2'd2; end
            4: begin RedPixels[1][1] = 2'd3; RedPixels[7][2] = 2'd3; end
            5: GrnPixels[7][3] = 2'd3;
            9: begin RedPixels = '1; GrnPixels = '1; end
            default: ;
        endcase
        curId      = id;
        FrameValid = valid;
    endtask

    task automatic modelReset();
        pos      = 0;
        mActive  = 0;
        mShadow  = 0;
        mPending = 1'b0;
        bndQ     = 1'b0;
    endtask

    // One clock: advance the model, then compare every output #1 after the edge.
    task automatic stepCycle();
        int prevPos;
        int prevActive;
        int r;
        int ph;
        bit en;
        bit bnd;
        bit cap;
        bit expStart;
        prevPos    = pos;
        prevActive = mActive;
        en         = EnableCount;
        bnd        = en && ((pos % 256) == 255);
        cap        = FrameValid && !mPending;
        @(posedge CLK);
        #1;
        expStart = bndQ;
        bndQ     = bnd;
        if (bnd && mPending) begin
            mActive  = mShadow;
            mPending = 1'b0;
        end else if (cap) begin
            mShadow  = curId;
            mPending = 1'b1;
        end
        if (en) pos++;
        r  = (prevPos / 16) % 16;
        ph = (prevPos / 4) % 4;
        checkOutput("rowsel", 32'(RowSel), 32'(r));
        checkOutput("redcols", 32'(RedCols), 32'(expRed(prevActive, r, ph)));
        checkOutput("grncols", 32'(GrnCols), 32'(expGrn(prevActive, r, ph)));
        checkOutput("framestart", 32'(FrameStart), 32'(expStart));
        checkOutput("frameready", 32'(FrameReady), 32'(!mPending));
    endtask

    task automatic runTo(input int target);
        while (pos < target) stepCycle();
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_rowsel"}, 32'(RowSel), 32'd0);
        checkOutput({tag, "_red"}, 32'(RedCols), 32'd0);
        checkOutput({tag, "_grn"}, 32'(GrnCols), 32'd0);
        checkOutput({tag, "_start"}, 32'(FrameStart), 32'd0);
        checkOutput({tag, "_ready"}, 32'(FrameReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] led_matrix_pwm_driver directed test");
        applyStimulus(0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        checkQuiet("reset");
        RST_N       = 1'b1;
        EnableCount = 1'b1;
        modelReset();

        // Free-running scan with no frame: dark, row steps every 16 cycles.
        runTo(17);
        checkOutput("row_step", 32'(RowSel), 32'd1);
        runTo(257);
        checkOutput("first_framestart", 32'(FrameStart), 32'd1);
        checkOutput("first_framestart_row", 32'(RowSel), 32'd0);

        // Frame 1 captured mid-frame; must not appear before the boundary.
        runTo(300);
        applyStimulus(1, 1'b1);
        stepCycle();
        applyStimulus(9, 1'b0);
        checkOutput("f1_ready_drop", 32'(FrameReady), 32'd0);
        runTo(305);
        checkOutput("f1_no_tear", 32'(RedCols), 32'h0000);
        runTo(561);
        checkOutput("f1_row3_ph0_red", 32'(RedCols), 32'h8000);
        checkOutput("f1_row3_ph0_grn", 32'(GrnCols), 32'h0001);
        runTo(565);
        checkOutput("f1_row3_ph1_red", 32'(RedCols), 32'h8000);
        checkOutput("f1_row3_ph1_grn", 32'(GrnCols), 32'h0000);
        runTo(573);
        checkOutput("f1_row3_ph3_red", 32'(RedCols), 32'h0000);
        checkOutput("f1_ready_back", 32'(FrameReady), 32'd1);

        // Frame 2 mid-scan, frame 3 offered with Valid held high.
        runTo(600);
        applyStimulus(2, 1'b1);
        stepCycle();
        applyStimulus(9, 1'b0);
        runTo(650);
        applyStimulus(3, 1'b1);
        runTo(700);
        checkOutput("held_not_accepted", 32'(FrameReady), 32'd0);
        runTo(769);
        checkOutput("f2_swap_grn", 32'(GrnCols), 32'h8000);
        checkOutput("held_accepted", 32'(FrameReady), 32'd0);
        runTo(780);
        applyStimulus(9, 1'b0);
        runTo(1025);
        checkOutput("f3_swap_red", 32'(RedCols), 32'h0001);

        // Capture exactly on the boundary tick with nothing pending.
        runTo(1279);
        applyStimulus(4, 1'b1);
        stepCycle();
        applyStimulus(9, 1'b0);
        checkOutput("bnd_capture_pending", 32'(FrameReady), 32'd0);
        runTo(1281);
        checkOutput("bnd_capture_not_yet", 32'(RedCols), 32'h0001);
        runTo(1553);
        checkOutput("bnd_capture_shown", 32'(RedCols), 32'h4000);

        // Freeze at row 7 phase 2 and accept a frame while frozen.
        runTo(1658);
        EnableCount = 1'b0;
        repeat (10) stepCycle();
        applyStimulus(5, 1'b1);
        stepCycle();
        applyStimulus(9, 1'b0);
        repeat (89) stepCycle();
        checkOutput("frozen_rowsel", 32'(RowSel), 32'd7);
        checkOutput("frozen_red", 32'(RedCols), 32'h2000);
        checkOutput("frozen_ready", 32'(FrameReady), 32'd0);
        EnableCount = 1'b1;
        runTo(1660);
        checkOutput("resume_ph2", 32'(RedCols), 32'h2000);
        runTo(1661);
        checkOutput("resume_ph3", 32'(RedCols), 32'h0000);

        // Freeze on the boundary position: no swap until scanning resumes.
        runTo(1791);
        EnableCount = 1'b0;
        repeat (10) stepCycle();
        checkOutput("frozen_bnd_ready", 32'(FrameReady), 32'd0);
        checkOutput("frozen_bnd_row", 32'(RowSel), 32'd15);
        EnableCount = 1'b1;

        // Leave frame 1 pending, then reset asynchronously mid-frame.
        runTo(1850);
        applyStimulus(1, 1'b1);
        stepCycle();
        applyStimulus(9, 1'b0);
        runTo(1905);
        checkOutput("f5_shown", 32'(GrnCols), 32'h1000);
        checkOutput("pre_reset_pending", 32'(FrameReady), 32'd0);
        applyStimulus(0, 1'b0);
        #1;
        RST_N = 1'b0;
        #1;
        checkQuiet("async_reset");
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        modelReset();
        runTo(305);
        checkOutput("dark_after_reset", 32'(RedCols), 32'h0000);
        checkOutput("ready_after_reset", 32'(FrameReady), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
